// File: rtl/cr_resid_blk_reorder.sv
// cr_resid_blk_reorder
// Chroma residual reorder buffer. Accepts an 8x8 chroma residual MB as
// 2 pixels per beat in raster order (32 beats) and re-emits it as four
// 4x4 sub-blocks (TL, TR, BL, BR), one 4-pixel row per beat (16 beats).
// Two storage banks ping-pong so one MB can fill while the other drains.
//
// Optional feature, compile-time macro CR_DC_SUM_EN:
//   adds dst_dc_sum, the unsigned sum of the 16 pixels of the sub-block
//   currently presented, accumulated per bank while the MB is written.
module cr_resid_blk_reorder #(
   parameter int MB_SIZE     = 8,
   parameter int PIXEL_WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     src_valid,
   output logic                     src_ready,
   input  logic [2*PIXEL_WIDTH-1:0] src_data,
   output logic                     dst_valid,
   input  logic                     dst_ready,
   output logic [4*PIXEL_WIDTH-1:0] dst_data,
   output logic [1:0]               dst_blk_idx,
   output logic [1:0]               dst_row_idx,
   output logic                     dst_last
`ifdef CR_DC_SUM_EN
   ,
   output logic [PIXEL_WIDTH+3:0]   dst_dc_sum
`endif
);

   localparam int PIX_PER_MB = MB_SIZE * MB_SIZE;
   localparam int ADDR_W     = $clog2(PIX_PER_MB);

   typedef logic [PIXEL_WIDTH-1:0] pixel_t;
   typedef logic [ADDR_W-1:0]      addr_t;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   pixel_t     mem [2][PIX_PER_MB];
   logic [4:0] wr_cnt;
   logic [3:0] rd_cnt;
   logic       wr_bank;
   logic       rd_bank;
   logic [1:0] full;
   logic [1:0] full_nxt;

   logic       wr_fire;
   logic       rd_fire;
   logic       wr_done;
   logic       rd_done;

   // Handshakes and end-of-MB detection
   always_comb begin
      src_ready = reset && !full[wr_bank];
      dst_valid = full[rd_bank];
      wr_fire   = src_valid && src_ready;
      rd_fire   = dst_valid && dst_ready;
      wr_done   = wr_fire && (wr_cnt == 5'd31);
      rd_done   = rd_fire && (rd_cnt == 4'd15);
   end

   // Full-flag update: a completed write sets its bank, a completed read
   // clears its bank. Both can happen in one cycle; they never share a bank.
   always_comb begin
      // NOTE: every always_comb output is assigned a default first, so no
      // path through the block can leave it unassigned and infer a latch.
      full_nxt = full;
      if (wr_done) full_nxt[wr_bank] = 1'b1;
      if (rd_done) full_nxt[rd_bank] = 1'b0;
   end

   // Write/read counters, bank pointers and full flags
   always_ff @(posedge clk or negedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values, independent of statement order.
      if (!reset) begin
         wr_cnt  <= '0;
         rd_cnt  <= '0;
         wr_bank <= 1'b0;
         rd_bank <= 1'b0;
         full    <= '0;
      end else begin
         full <= full_nxt;
         if (wr_fire) begin
            wr_cnt <= wr_cnt + 5'd1;
            if (wr_done) wr_bank <= ~wr_bank;
         end
         if (rd_fire) begin
            rd_cnt <= rd_cnt + 4'd1;
            if (rd_done) rd_bank <= ~rd_bank;
         end
      end
   end

   // Pixel storage write: beat n carries row n/4, columns 2*(n%4) and
   // 2*(n%4)+1, which is raster address {wr_cnt, 0} and {wr_cnt, 1}.
   always_ff @(posedge clk) begin
      // NOTE: the pixel array has no reset; the full flags guard every read,
      // so stale contents are never presented as valid data.
      if (wr_fire) begin
         mem[wr_bank][{wr_cnt, 1'b0}] <= src_data[PIXEL_WIDTH-1:0];
         mem[wr_bank][{wr_cnt, 1'b1}] <= src_data[2*PIXEL_WIDTH-1:PIXEL_WIDTH];
      end
   end

   // ------------------------------------------------------------------
   // Read side: rd_cnt = {blk[1], blk[0], row[1:0]}.
   // Source raster row is {blk[1], row}, column base is {blk[0], 2'b00}.
   // ------------------------------------------------------------------
   addr_t rd_addr [4];

   // Addresses of the four pixels of the current 4x4 row
   always_comb begin
      for (int k = 0; k < 4; k++) begin
         rd_addr[k] = {rd_cnt[3], rd_cnt[1:0], rd_cnt[2], 2'(k)};
      end
   end

   // Output row and beat tags, all combinational from rd_cnt and storage
   always_comb begin
      dst_data = '0;
      for (int k = 0; k < 4; k++) begin
         dst_data[k*PIXEL_WIDTH +: PIXEL_WIDTH] = mem[rd_bank][rd_addr[k]];
      end
      dst_blk_idx = rd_cnt[3:2];
      dst_row_idx = rd_cnt[1:0];
      dst_last    = dst_valid && (rd_cnt == 4'd15);
   end

`ifdef CR_DC_SUM_EN
   // ------------------------------------------------------------------
   // DC sums: one accumulator per sub-block per bank. A write beat lies
   // wholly inside sub-block {row[2], col[2]} = {wr_cnt[4], wr_cnt[1]}.
   // 16 pixels of at most 2^PW-1 fit in PW+4 bits without overflow.
   // ------------------------------------------------------------------
   typedef logic [PIXEL_WIDTH+3:0] dc_t;

   dc_t        dc_acc [2][4];
   dc_t        pair_sum;
   logic [1:0] wr_blk;

   // Sum of the two pixels of the incoming beat and their sub-block
   always_comb begin
      pair_sum = dc_t'(src_data[PIXEL_WIDTH-1:0])
               + dc_t'(src_data[2*PIXEL_WIDTH-1:PIXEL_WIDTH]);
      wr_blk   = {wr_cnt[4], wr_cnt[1]};
   end

   // Accumulate per sub-block; the first beat of an MB restarts all four
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int b = 0; b < 2; b++) begin
            for (int s = 0; s < 4; s++) begin
               dc_acc[b][s] <= '0;
            end
         end
      end else if (wr_fire) begin
         for (int s = 0; s < 4; s++) begin
            if (wr_cnt == 5'd0) begin
               dc_acc[wr_bank][s] <= (s == 0) ? pair_sum : '0;
            end else if (wr_blk == 2'(s)) begin
               dc_acc[wr_bank][s] <= dc_acc[wr_bank][s] + pair_sum;
            end
         end
      end
   end

   // Present the sum of the sub-block currently being drained
   always_comb begin
      dst_dc_sum = dc_acc[rd_bank][rd_cnt[3:2]];
   end
`endif

endmodule

// File: tb/tb_cr_resid_blk_reorder.sv
// Directed testbench for cr_resid_blk_reorder.
// Compile with +define+CR_DC_SUM_EN to also check the DC-sum output.
module tb_cr_resid_blk_reorder;

   localparam int PW = 8;

   logic            clk = 1'b0;
   logic            reset;
   logic            src_valid;
   logic            src_ready;
   logic [2*PW-1:0] src_data;
   logic            dst_valid;
   logic            dst_ready;
   logic [4*PW-1:0] dst_data;
   logic [1:0]      dst_blk_idx;
   logic [1:0]      dst_row_idx;
   logic            dst_last;
`ifdef CR_DC_SUM_EN
   logic [PW+3:0]   dst_dc_sum;
`endif

   int n_cmp = 0;
   int n_err = 0;
   int in_pat [4];
   int out_pat[4];

   cr_resid_blk_reorder #(.MB_SIZE(8), .PIXEL_WIDTH(PW)) dut (
      .clk        (clk),
      .reset      (reset),
      .src_valid  (src_valid),
      .src_ready  (src_ready),
      .src_data   (src_data),
      .dst_valid  (dst_valid),
      .dst_ready  (dst_ready),
      .dst_data   (dst_data),
      .dst_blk_idx(dst_blk_idx),
      .dst_row_idx(dst_row_idx),
      .dst_last   (dst_last)
`ifdef CR_DC_SUM_EN
      ,
      .dst_dc_sum (dst_dc_sum)
`endif
   );

   always #5 clk = ~clk;

   // Pixel patterns: 0 = 8r+c, 1 = 63-(8r+c), 2 = all 255,
   // 3 = 200-(8r+c), 4 = (8r+c)^A5, 5 = 8r+c+128
   function automatic logic [PW-1:0] pix(int p, int r, int c);
      int v;
      v = 8 * r + c;
      case (p)
         0:       return 8'(v);
         1:       return 8'(63 - v);
         2:       return 8'hFF;
         3:       return 8'(200 - v);
         4:       return 8'(v ^ 'hA5);
         default: return 8'(v + 128);
      endcase
   endfunction

   // Raster input beat b (0..31): odd column in the upper half
   function automatic logic [2*PW-1:0] beat_in(int p, int b);
      return {pix(p, b / 4, 2 * (b % 4) + 1), pix(p, b / 4, 2 * (b % 4))};
   endfunction

   // Expected output row j (0..15): sub-block j/4, row j%4
   function automatic logic [4*PW-1:0] exp_row(int p, int j);
      int blk, r, c0;
      blk = j / 4;
      r   = (blk / 2) * 4 + (j % 4);
      c0  = (blk % 2) * 4;
      return {pix(p, r, c0 + 3), pix(p, r, c0 + 2), pix(p, r, c0 + 1), pix(p, r, c0)};
   endfunction

   function automatic logic [PW+3:0] exp_dc(int p, int blk);
      int s;
      s = 0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            s += int'(pix(p, (blk / 2) * 4 + r, (blk % 2) * 4 + c));
      return (PW + 4)'(s);
   endfunction

   // Streaming engine: feeds n_in MBs from in_pat[], expects n_out MBs
   // from out_pat[]. mode 0: dst_ready always 1; mode 1: 1,0,1,0,...
   task automatic run_stream(input string name, input int n_in, input int n_out,
                             input int mode, output int stalls);
      int in_idx, out_idx, cyc, m, j;
      logic r;
      logic [4*PW+4:0] exp_v;
      in_idx = 0; out_idx = 0; cyc = 0; stalls = 0;
      while ((in_idx < n_in * 32 || out_idx < n_out * 16) && cyc < 2000) begin
         @(negedge clk);
         r = (mode == 0) ? 1'b1 : ((cyc % 2) == 0);
         dst_ready = r;
         if (dst_valid && r) begin
            m = out_idx / 16;
            j = out_idx % 16;
            exp_v = {exp_row(out_pat[m], j), 2'(j / 4), 2'(j % 4), (j == 15)};
            n_cmp++;
            if ({dst_data, dst_blk_idx, dst_row_idx, dst_last} !== exp_v) begin
               n_err++;
               $display("FAIL %s mb%0d beat%0d: got data=%h blk=%0d row=%0d last=%b, want data=%h blk=%0d row=%0d last=%b",
                        name, m, j, dst_data, dst_blk_idx, dst_row_idx, dst_last,
                        exp_v[36:5], exp_v[4:3], exp_v[2:1], exp_v[0]);
            end
`ifdef CR_DC_SUM_EN
            n_cmp++;
            if (dst_dc_sum !== exp_dc(out_pat[m], j / 4)) begin
               n_err++;
               $display("FAIL %s dc_sum mb%0d beat%0d: got %0d, want %0d",
                        name, m, j, dst_dc_sum, exp_dc(out_pat[m], j / 4));
            end
`endif
            out_idx++;
         end
         if (in_idx < n_in * 32) begin
            src_valid = 1'b1;
            src_data  = beat_in(in_pat[in_idx / 32], in_idx % 32);
            if (src_ready) in_idx++;
            else if (in_idx > 0) stalls++;
         end else begin
            src_valid = 1'b0;
         end
         cyc++;
      end
      if (cyc >= 2000) begin
         n_cmp++; n_err++;
         $display("FAIL %s timeout: got in=%0d out=%0d, want in=%0d out=%0d",
                  name, in_idx, out_idx, n_in * 32, n_out * 16);
      end
      @(negedge clk);
      src_valid = 1'b0;
      dst_ready = 1'b0;
      n_cmp++;
      if (dst_valid !== 1'b0) begin
         n_err++;
         $display("FAIL %s trailing dst_valid: got %b, want 0", name, dst_valid);
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({dst_valid, dst_last, dst_blk_idx, dst_row_idx, src_ready} !== 7'b0) begin
         n_err++;
         $display("FAIL reset_state: got valid=%b last=%b blk=%0d row=%0d src_ready=%b, want all 0",
                  dst_valid, dst_last, dst_blk_idx, dst_row_idx, src_ready);
      end
`ifdef CR_DC_SUM_EN
      n_cmp++;
      if (dst_dc_sum !== '0) begin
         n_err++;
         $display("FAIL reset_dc_sum: got %0d, want 0", dst_dc_sum);
      end
`endif
      reset = 1'b1;
      #1;
      n_cmp++;
      if ({src_ready, dst_valid} !== 2'b10) begin
         n_err++;
         $display("FAIL reset_release: got src_ready=%b dst_valid=%b, want 1 0", src_ready, dst_valid);
      end
   endtask

   task automatic test_single_mb();
      logic [4*PW-1:0] spot [4];
      int spot_j [4];
      logic [4*PW+4:0] exp_v;
      spot[0] = 32'h03020100; spot_j[0] = 0;
      spot[1] = 32'h07060504; spot_j[1] = 4;
      spot[2] = 32'h23222120; spot_j[2] = 8;
      spot[3] = 32'h3F3E3D3C; spot_j[3] = 15;
      dst_ready = 1'b1;
      for (int b = 0; b < 32; b++) begin
         @(negedge clk);
         n_cmp++;
         if (dst_valid !== 1'b0 || src_ready !== 1'b1) begin
            n_err++;
            $display("FAIL single_fill beat%0d: got dst_valid=%b src_ready=%b, want 0 1", b, dst_valid, src_ready);
         end
         src_valid = 1'b1;
         src_data  = beat_in(0, b);
      end
      @(negedge clk);
      src_valid = 1'b0;
      n_cmp++;
      if (dst_valid !== 1'b1) begin
         n_err++;
         $display("FAIL single_latency: got dst_valid=%b, want 1", dst_valid);
      end
      for (int j = 0; j < 16; j++) begin
         if (j > 0) @(negedge clk);
         exp_v = {exp_row(0, j), 2'(j / 4), 2'(j % 4), (j == 15)};
         n_cmp++;
         if ({dst_valid, dst_data, dst_blk_idx, dst_row_idx, dst_last} !== {1'b1, exp_v}) begin
            n_err++;
            $display("FAIL single_beat%0d: got valid=%b data=%h blk=%0d row=%0d last=%b, want data=%h",
                     j, dst_valid, dst_data, dst_blk_idx, dst_row_idx, dst_last, exp_v[36:5]);
         end
         for (int s = 0; s < 4; s++) begin
            if (spot_j[s] == j) begin
               n_cmp++;
               if (dst_data !== spot[s]) begin
                  n_err++;
                  $display("FAIL single_spot beat%0d: got %h, want %h", j, dst_data, spot[s]);
               end
            end
         end
      end
      @(negedge clk);
      dst_ready = 1'b0;
      n_cmp++;
      if (dst_valid !== 1'b0) begin
         n_err++;
         $display("FAIL single_end: got dst_valid=%b, want 0", dst_valid);
      end
   endtask

   task automatic test_backpressure();
      int stalls;
      dst_ready = 1'b0;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         n_cmp++;
         if (src_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_accept beat%0d: got src_ready=%b, want 1", i, src_ready);
         end
         src_valid = 1'b1;
         src_data  = beat_in((i < 32) ? 0 : 1, i % 32);
      end
      @(negedge clk);
      src_valid = 1'b1;
      src_data  = beat_in(5, 0);
      n_cmp++;
      if (src_ready !== 1'b0) begin
         n_err++;
         $display("FAIL bp_stall beat65: got src_ready=%b, want 0", src_ready);
      end
      for (int h = 0; h < 5; h++) begin
         @(negedge clk);
         n_cmp++;
         if ({src_ready, dst_valid, dst_data, dst_blk_idx, dst_row_idx} !== {2'b01, exp_row(0, 0), 4'b0}) begin
            n_err++;
            $display("FAIL bp_hold cycle%0d: got src_ready=%b valid=%b data=%h blk=%0d row=%0d, want 0 1 %h 0 0",
                     h, src_ready, dst_valid, dst_data, dst_blk_idx, dst_row_idx, exp_row(0, 0));
         end
      end
      in_pat[0]  = 5;
      out_pat[0] = 0; out_pat[1] = 1; out_pat[2] = 5;
      run_stream("bp_drain", 1, 3, 0, stalls);
   endtask

   task automatic test_back_to_back();
      int stalls;
      in_pat[0]  = 0; in_pat[1]  = 1;
      out_pat[0] = 0; out_pat[1] = 1;
      run_stream("b2b", 2, 2, 1, stalls);
      n_cmp++;
      if (stalls !== 0) begin
         n_err++;
         $display("FAIL b2b_stalls: got %0d, want 0", stalls);
      end
   endtask

   task automatic test_reset_mid_mb();
      int stalls;
      dst_ready = 1'b0;
      for (int i = 0; i < 42; i++) begin
         @(negedge clk);
         src_valid = 1'b1;
         src_data  = beat_in(3, i % 32);
      end
      @(negedge clk);
      src_valid = 1'b0;
      n_cmp++;
      if (dst_valid !== 1'b1) begin
         n_err++;
         $display("FAIL rst_pre: got dst_valid=%b, want 1", dst_valid);
      end
      #2;
      reset = 1'b0;
      #1;
      n_cmp++;
      if ({dst_valid, src_ready, dst_last, dst_blk_idx, dst_row_idx} !== 7'b0) begin
         n_err++;
         $display("FAIL rst_async: got valid=%b src_ready=%b last=%b blk=%0d row=%0d, want all 0",
                  dst_valid, src_ready, dst_last, dst_blk_idx, dst_row_idx);
      end
      @(negedge clk);
      n_cmp++;
      if (src_ready !== 1'b0) begin
         n_err++;
         $display("FAIL rst_hold: got src_ready=%b, want 0", src_ready);
      end
      reset = 1'b1;
      #1;
      n_cmp++;
      if ({src_ready, dst_valid} !== 2'b10) begin
         n_err++;
         $display("FAIL rst_release: got src_ready=%b dst_valid=%b, want 1 0", src_ready, dst_valid);
      end
      in_pat[0]  = 4;
      out_pat[0] = 4;
      run_stream("rst_recover", 1, 1, 0, stalls);
   endtask

`ifdef CR_DC_SUM_EN
   task automatic test_dc_sum();
      int stalls;
      logic [PW+3:0] hand [4];
      hand[0] = 216; hand[1] = 280; hand[2] = 728; hand[3] = 792;
      for (int b = 0; b < 4; b++) begin
         n_cmp++;
         if (exp_dc(0, b) !== hand[b]) begin
            n_err++;
            $display("FAIL dc_model blk%0d: got %0d, want %0d", b, exp_dc(0, b), hand[b]);
         end
      end
      in_pat[0]  = 0; in_pat[1]  = 2;
      out_pat[0] = 0; out_pat[1] = 2;
      run_stream("dc", 2, 2, 0, stalls);
   endtask
`endif

   initial begin
      reset     = 1'b0;
      src_valid = 1'b0;
      src_data  = '0;
      dst_ready = 1'b0;
      test_reset();
      test_single_mb();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_mb();
`ifdef CR_DC_SUM_EN
      test_dc_sum();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion by 200000ns, want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
